// File: rtl/cubehash_msg_pad.sv
// Byte-serial feeder for the CubeHash core: paces payload bytes onto part_msg under load
// pulses and appends 0x80/0x00 padding to a full block. Optional macro: CUBEHASH_PAD_LEN_EN.
`timescale 1ns/1ps
module cubehash_msg_pad #(
  parameter int LOAD_CYCLES = 10,
  parameter int GAP_CYCLES  = 12,
  parameter int BLOCK_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        core_busy,
  output logic        in_en,
  output logic        start,
  output logic        load,
  output logic [7:0]  part_msg,
  output logic        pad_done,
  output logic        err
`ifdef CUBEHASH_PAD_LEN_EN
  ,
  output logic [31:0] msg_len,
  output logic [5:0]  pad_len
`endif
);

  localparam int         CNT_W     = $clog2(BLOCK_BYTES);
  localparam logic [7:0] LOAD_INIT = 8'(LOAD_CYCLES - 1);
  localparam logic [7:0] GAP_INIT  = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_LOAD      = 3'd2,
    ST_GAP       = 3'd3,
    ST_PAD       = 3'd4,
    ST_BLK_WAIT  = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]         timer_q, timer_d;
  logic [7:0]         part_msg_q, part_msg_d;
  logic               last_seen_q, last_seen_d;
  logic               pad_sent_q, pad_sent_d;
  logic               load_q, load_d;
  logic               in_en_q, in_en_d;
  logic               start_q, start_d;
  logic               pad_done_q, pad_done_d;
  logic               err_q, err_d;
  logic               s_ready_q, s_ready_d;
  logic               accept_s;
  logic               msg_go_s;
  logic               err_set_s;

  assign accept_s  = (state_q == ST_WAIT_BYTE) && s_valid && s_ready_q;
  assign msg_go_s  = (state_q == ST_IDLE) && msg_start;
  // Bytes offered after the terminator, or a restart request mid-message, are protocol errors.
  assign err_set_s = (msg_start && (state_q != ST_IDLE)) ||
                     (s_valid && last_seen_q &&
                      ((state_q == ST_LOAD) || (state_q == ST_GAP) || (state_q == ST_PAD)));

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    timer_d     = timer_q;
    part_msg_d  = part_msg_q;
    last_seen_d = last_seen_q;
    pad_sent_d  = pad_sent_q;
    load_d      = load_q;
    in_en_d     = in_en_q;
    start_d     = start_q;
    pad_done_d  = 1'b0;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (msg_start) begin
          in_en_d     = 1'b1;
          start_d     = 1'b1;
          err_d       = 1'b0;
          byte_cnt_d  = '0;
          last_seen_d = 1'b0;
          pad_sent_d  = 1'b0;
          state_d     = ST_WAIT_BYTE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_BYTE: begin
        if (accept_s) begin
          part_msg_d  = s_data;
          last_seen_d = s_last;
          byte_cnt_d  = byte_cnt_q + CNT_W'(1);
          load_d      = 1'b1;
          timer_d     = LOAD_INIT;
          state_d     = ST_LOAD;
        end else begin
          state_d = ST_WAIT_BYTE;
        end
      end
      ST_LOAD: begin
        if (timer_q == 8'd0) begin
          load_d  = 1'b0;
          timer_d = GAP_INIT;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (timer_q != 8'd0) begin
          timer_d = timer_q - 8'd1;
        end else if (byte_cnt_q == '0) begin
          state_d = ST_BLK_WAIT;
        end else if (last_seen_q) begin
          state_d = ST_PAD;
        end else begin
          state_d = ST_WAIT_BYTE;
        end
      end
      ST_PAD: begin
        part_msg_d = pad_sent_q ? 8'h00 : 8'h80;
        pad_sent_d = 1'b1;
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        load_d     = 1'b1;
        timer_d    = LOAD_INIT;
        state_d    = ST_LOAD;
      end
      ST_BLK_WAIT: begin
        // A block carrying the 0x80 is necessarily the final one.
        if (core_busy) begin
          state_d = ST_BLK_WAIT;
        end else if (pad_sent_q) begin
          pad_done_d = 1'b1;
          state_d    = ST_DONE;
        end else if (last_seen_q) begin
          state_d = ST_PAD;
        end else begin
          state_d = ST_WAIT_BYTE;
        end
      end
      ST_DONE: begin
        in_en_d = 1'b0;
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (err_set_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
    s_ready_d = (state_d == ST_WAIT_BYTE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      timer_q     <= 8'd0;
      part_msg_q  <= 8'h00;
      last_seen_q <= 1'b0;
      pad_sent_q  <= 1'b0;
      load_q      <= 1'b0;
      in_en_q     <= 1'b0;
      start_q     <= 1'b0;
      pad_done_q  <= 1'b0;
      err_q       <= 1'b0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      timer_q     <= timer_d;
      part_msg_q  <= part_msg_d;
      last_seen_q <= last_seen_d;
      pad_sent_q  <= pad_sent_d;
      load_q      <= load_d;
      in_en_q     <= in_en_d;
      start_q     <= start_d;
      pad_done_q  <= pad_done_d;
      err_q       <= err_d;
      s_ready_q   <= s_ready_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign in_en    = in_en_q;
  assign start    = start_q;
  assign load     = load_q;
  assign part_msg = part_msg_q;
  assign pad_done = pad_done_q;
  assign err      = err_q;

`ifdef CUBEHASH_PAD_LEN_EN
  logic [31:0] msg_len_q, msg_len_d;
  logic [5:0]  pad_len_q, pad_len_d;

  // Length counters: payload count saturates, pad count covers at most one block.
  always_comb begin
    msg_len_d = msg_len_q;
    pad_len_d = pad_len_q;
    if (msg_go_s) begin
      msg_len_d = 32'd0;
      pad_len_d = 6'd0;
    end else if (accept_s && (msg_len_q != 32'hFFFF_FFFF)) begin
      msg_len_d = msg_len_q + 32'd1;
    end else if (state_q == ST_PAD) begin
      pad_len_d = pad_len_q + 6'd1;
    end else begin
      msg_len_d = msg_len_q;
    end
  end

  // Length counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_len_q <= 32'd0;
      pad_len_q <= 6'd0;
    end else begin
      msg_len_q <= msg_len_d;
      pad_len_q <= pad_len_d;
    end
  end

  assign msg_len = msg_len_q;
  assign pad_len = pad_len_q;
`else
  logic unused_s;
  assign unused_s = msg_go_s;
`endif

endmodule

// File: tb/tb_cubehash_msg_pad.sv
// Directed bench for cubehash_msg_pad: byte sequences, pulse timing, busy throttling,
// error flag and asynchronous reset, with hand-derived expected streams.
`timescale 1ns/1ps
module tb_cubehash_msg_pad;
  localparam int LOAD_CYCLES = 10;
  localparam int GAP_CYCLES  = 12;
  localparam int BLOCK_BYTES = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       msg_start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       core_busy = 1'b0;
  logic       s_ready, in_en, start, load, pad_done, err;
  logic [7:0] part_msg;
`ifdef CUBEHASH_PAD_LEN_EN
  logic [31:0] msg_len;
  logic [5:0]  pad_len;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int exp_len = 0;
  int exp_pad = 0;
  logic abort = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  cubehash_msg_pad #(
    .LOAD_CYCLES(LOAD_CYCLES), .GAP_CYCLES(GAP_CYCLES), .BLOCK_BYTES(BLOCK_BYTES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .msg_start(msg_start), .s_valid(s_valid),
    .s_data(s_data), .s_last(s_last), .s_ready(s_ready), .core_busy(core_busy),
    .in_en(in_en), .start(start), .load(load), .part_msg(part_msg),
    .pad_done(pad_done), .err(err)
`ifdef CUBEHASH_PAD_LEN_EN
    , .msg_len(msg_len), .pad_len(pad_len)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: captures each presented byte and checks pulse widths and done framing.
  initial begin
    logic load_p, pd_p;
    int hi_cnt, lo_cnt;
    load_p = 1'b0; pd_p = 1'b0; hi_cnt = 0; lo_cnt = 100;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        load_p = 1'b0; pd_p = 1'b0; hi_cnt = 0; lo_cnt = 100;
      end else begin
        if (load && !load_p) begin
          chk("load_low_min", 32'(lo_cnt >= GAP_CYCLES), 32'd1);
          got_q.push_back(part_msg);
          hi_cnt = 1;
        end else if (load) begin
          hi_cnt++;
        end else if (load_p) begin
          chk("load_high_width", 32'(hi_cnt), 32'(LOAD_CYCLES));
          if (got_q.size() > 0) chk("part_msg_stable", 32'(part_msg), 32'(got_q[got_q.size()-1]));
          lo_cnt = 1;
        end else begin
          lo_cnt++;
        end
        if (pad_done) begin
          done_cnt++;
          chk("framing_at_done", 32'({in_en, start}), 32'd3);
`ifdef CUBEHASH_PAD_LEN_EN
          chk("msg_len", msg_len, 32'(exp_len));
          chk("pad_len", 32'(pad_len), 32'(exp_pad));
`endif
        end
        if (pd_p) chk("drop_after_done", 32'({pad_done, in_en, start}), 32'd0);
        load_p = load;
        pd_p = pad_done;
      end
    end
  end

  task automatic build_exp(input int n, input logic [7:0] first, input logic [7:0] step);
    int total;
    exp_q.delete();
    got_q.delete();
    total = (n / BLOCK_BYTES + 1) * BLOCK_BYTES;
    for (int i = 0; i < n; i++) exp_q.push_back(first + 8'(i) * step);
    exp_q.push_back(8'h80);
    while (exp_q.size() < total) exp_q.push_back(8'h00);
    exp_len = n;
    exp_pad = total - n;
  endtask

  task automatic run_msg(input int n, input logic [7:0] first, input logic [7:0] step);
    int budget;
    @(negedge clk); msg_start = 1'b1;
    @(negedge clk); msg_start = 1'b0;
    chk("err_clear_on_start", 32'(err), 32'd0);
    for (int i = 0; i < n; i++) begin
      s_data = first + 8'(i) * step;
      s_last = (i == n - 1);
      s_valid = 1'b1;
      budget = 0;
      while (!s_ready && !abort && budget < 3000) begin
        @(negedge clk);
        budget++;
      end
      if (abort) begin
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      if (!s_ready) begin
        chk("driver_timeout", 32'd0, 32'd1);
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_done();
    int saved, budget;
    saved = done_cnt;
    budget = 0;
    while (done_cnt == saved && budget < 4000) begin
      @(negedge clk);
      budget++;
    end
    repeat (4) @(negedge clk);
    chk("pad_done_count", 32'(done_cnt - saved), 32'd1);
  endtask

  task automatic wait_pulses(input int k);
    int budget;
    budget = 0;
    while (got_q.size() < k && budget < 4000) begin
      @(negedge clk);
      budget++;
    end
    chk("pulse_wait", 32'(got_q.size() >= k), 32'd1);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic run_full(input string tag, input int n, input logic [7:0] first, input logic [7:0] step);
    build_exp(n, first, step);
    run_msg(n, first, step);
    wait_done();
    check_seq(tag);
  endtask

  initial begin
    int viol, cnt, saved;
    #2;
    chk("rst_outputs", 32'({s_ready, in_en, start, load, pad_done, err}), 32'd0);
    chk("rst_part_msg", 32'(part_msg), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Upstream valid while idle is neither accepted nor an error.
    s_valid = 1'b1; s_data = 8'h5A;
    repeat (4) @(negedge clk);
    chk("idle_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_err", 32'(err), 32'd0);
    chk("idle_no_load", 32'(got_q.size()), 32'd0);

    run_full("short3", 3, 8'h00, 8'h00);
    chk("short3_err", 32'(err), 32'd0);

    run_full("full32", 32, 8'h01, 8'h01);

    // Core busy at the first block boundary holds everything off.
    build_exp(40, 8'h01, 8'h01);
    core_busy = 1'b1;
    fork
      run_msg(40, 8'h01, 8'h01);
      begin
        wait_pulses(32);
        cnt = 0;
        while (load && cnt < 100) begin @(negedge clk); cnt++; end
        repeat (GAP_CYCLES + 2) @(negedge clk);
        viol = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (s_ready || load) viol++;
        end
        chk("busy_hold_quiet", 32'(viol), 32'd0);
        chk("busy_hold_pulses", 32'(got_q.size()), 32'd32);
        core_busy = 1'b0;
        cnt = 0;
        while (!load && cnt < 20) begin @(negedge clk); cnt++; end
        chk("busy_release_latency", 32'(cnt), 32'd2);
      end
    join
    wait_done();
    check_seq("busy40");

    // Restart request mid-payload: flagged, stream untouched.
    build_exp(5, 8'h10, 8'h01);
    fork
      run_msg(5, 8'h10, 8'h01);
      begin
        wait_pulses(2);
        @(negedge clk); msg_start = 1'b1;
        @(negedge clk); msg_start = 1'b0;
        chk("err_mid_start", 32'(err), 32'd1);
      end
    join
    wait_done();
    check_seq("midstart5");
    chk("err_sticky", 32'(err), 32'd1);

    // Bytes offered after the terminator are refused and flagged.
    build_exp(2, 8'h61, 8'h01);
    run_msg(2, 8'h61, 8'h01);
    s_valid = 1'b1; s_data = 8'h55;
    repeat (5) @(negedge clk);
    s_valid = 1'b0;
    chk("err_after_last", 32'(err), 32'd1);
    wait_done();
    check_seq("after_last2");

    // Asynchronous reset during the fifth byte's load pulse.
    build_exp(8, 8'h30, 8'h01);
    fork
      run_msg(8, 8'h30, 8'h01);
      begin
        wait_pulses(5);
        repeat (3) @(negedge clk);
        chk("pre_rst_load", 32'(load), 32'd1);
        #2 rst_n = 1'b0; abort = 1'b1;
        #1;
        chk("async_rst_outputs", 32'({load, start, in_en}), 32'd0);
        chk("async_rst_part_msg", 32'(part_msg), 32'd0);
      end
    join
    @(negedge clk);
    rst_n = 1'b1; abort = 1'b0;
    saved = done_cnt;
    repeat (30) @(negedge clk);
    chk("no_done_after_rst", 32'(done_cnt), 32'(saved));
    chk("idle_after_rst", 32'({load, start, in_en}), 32'd0);

    run_full("post_rst3", 3, 8'hAA, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
    $fatal(1);
  end
endmodule
